// File: rtl/icache_ctrl_if.sv
// Fetch-side and instruction-memory-side signal bundle for icache_ctrl.
// master = fetch stage + IM (drives requests and IM data); slave = cache controller.
interface icache_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              flush;
    logic [DATA_W-1:0] instr_out;
    logic              ic_stall;
    logic [ADDR_W-1:0] im_addr;
    logic              im_en_read;
    logic [DATA_W-1:0] im_rdata;

    modport master (
        output cpu_req, cpu_addr, flush, im_rdata,
        input  instr_out, ic_stall, im_addr, im_en_read
    );

    modport slave (
        input  cpu_req, cpu_addr, flush, im_rdata,
        output instr_out, ic_stall, im_addr, im_en_read
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache controller; optional hit/miss counters with ICACHE_STATS_EN.
// Latency: hit served combinationally; miss costs 1 + WORDS_LINE + 1 stall cycles.
// Backpressure: ic_stall holds the fetch stage during miss, refill and flush cycles.
module icache_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINES      = 16,
    parameter int WORDS_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    icache_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int OFF_W = $clog2(WORDS_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_K = OFF_W'(WORDS_LINE - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REFILL    = 2'd1;
    localparam logic [1:0] FILL_WAIT = 2'd2;

    logic [1:0]        state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS_LINE];

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [OFF_W-1:0]  issue_k;
    logic [OFF_W-1:0]  cap_k;
    logic              cap_vld;
    logic              flush_pend;
    logic [DATA_W-1:0] instr_q;
    logic              lookup, hit, miss, flushing;

    assign req_off  = bus.cpu_addr[OFF_W+1:2];
    assign req_idx  = bus.cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag  = bus.cpu_addr[ADDR_W-1:IDX_W+OFF_W+2];

    assign lookup   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign flushing = (state == IDLE) && bus.flush;
    assign hit      = (state == IDLE) && bus.cpu_req && !bus.flush && lookup;
    assign miss     = (state == IDLE) && bus.cpu_req && !bus.flush && !lookup;

    assign bus.instr_out  = hit ? data_mem[{req_idx, req_off}] : instr_q;
    // Gated by rst so an aborted refill drops the stall in the same cycle.
    assign bus.ic_stall   = !rst && ((state != IDLE) || miss || flushing);
    assign bus.im_en_read = (state == REFILL);
    assign bus.im_addr    = (state == REFILL) ? {fill_tag, fill_idx, issue_k, 2'b00} : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            fill_idx   <= '0;
            fill_tag   <= '0;
            issue_k    <= '0;
            cap_k      <= '0;
            cap_vld    <= 1'b0;
            flush_pend <= 1'b0;
            instr_q    <= '0;
        end else begin
            // IM returns data one cycle after issue, so capture trails issue by one.
            cap_vld <= (state == REFILL);
            cap_k   <= issue_k;
            if (hit) begin
                instr_q <= data_mem[{req_idx, req_off}];
            end
            case (state)
                IDLE: begin
                    if (flushing) begin
                        valid <= '0;
                    end else if (miss) begin
                        fill_idx   <= req_idx;
                        fill_tag   <= req_tag;
                        issue_k    <= '0;
                        flush_pend <= 1'b0;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    issue_k <= issue_k + 1'b1;
                    if (issue_k == LAST_K) begin
                        state <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (flush_pend || bus.flush) begin
                        valid <= '0;
                    end else begin
                        valid[fill_idx] <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap_vld) begin
            data_mem[{fill_idx, cap_k}] <= bus.im_rdata;
        end
        if (state == FILL_WAIT) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // The cycle that serves a just-refilled line belongs to the miss, not a hit.
    logic refilled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            refilled <= 1'b0;
        end else begin
            refilled <= (state == FILL_WAIT);
            if (hit && !refilled && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
